// File: rtl/raizing_line_sched_if.sv
// Renderer handshake bundle between the line scheduler (master) and the
// sprite/tile renderer (slave).
interface raizing_line_sched_if;
    logic       render_req;
    logic       render_ack;
    logic       render_done;
    logic [8:0] render_line;
    logic       render_bank;
    logic       render_abort;

    modport master (
        output render_req,
        output render_line,
        output render_bank,
        output render_abort,
        input  render_ack,
        input  render_done
    );

    modport slave (
        input  render_req,
        input  render_line,
        input  render_bank,
        input  render_abort,
        output render_ack,
        output render_done
    );
endinterface

// File: rtl/raizing_line_sched.sv
// Per-scanline line-buffer scheduler: swaps banks at each line start, clears the
// render bank, then runs a req/ack/done handshake with the renderer.
module raizing_line_sched #(
    parameter int CLEAR_LEN = 320,
    parameter int LAST_LINE = 239
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        lhbl,
    input  logic [8:0]                  vrender,
    raizing_line_sched_if.master        rnd,
    output logic                        disp_bank,
    output logic                        clr_we,
    output logic [8:0]                  clr_addr,
    output logic                        overrun,
    output logic [7:0]                  overrun_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_BUSY  = 2'd3;

    localparam logic [8:0] CLR_LAST = 9'(CLEAR_LEN - 1);

    logic [1:0] r_state;
    logic       r_lhbl_d;
    logic       r_disp_bank;
    logic [8:0] r_render_line;
    logic [8:0] r_clr_addr;
    logic       r_overrun;
    logic       r_render_abort;
    logic [7:0] r_overrun_cnt;

    logic w_ls;
    logic w_done_now;
    logic w_overrun;
    logic w_abort;
    logic w_render_this;

    assign w_ls          = r_lhbl_d & ~lhbl;
    // A done pulse landing on the line-start edge still counts as completion.
    assign w_done_now    = (r_state == S_BUSY) & rnd.render_done;
    assign w_overrun     = w_ls & (r_state != S_IDLE) & ~w_done_now;
    assign w_abort       = w_overrun & ((r_state == S_REQ) | (r_state == S_BUSY));
    assign w_render_this = int'(vrender) <= LAST_LINE;

    // NOTE: reset is sampled on the clock edge only, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_lhbl_d       <= 1'b1;
            r_disp_bank    <= 1'b0;
            r_render_line  <= '0;
            r_clr_addr     <= '0;
            r_overrun      <= 1'b0;
            r_render_abort <= 1'b0;
            r_overrun_cnt  <= '0;
        end else begin
            r_lhbl_d       <= lhbl;
            r_overrun      <= w_overrun;
            r_render_abort <= w_abort;
            if (w_overrun && (r_overrun_cnt != 8'hff)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end

            if (w_ls) begin
                r_disp_bank   <= ~r_disp_bank;
                r_render_line <= vrender;
                r_clr_addr    <= '0;
                r_state       <= w_render_this ? S_CLEAR : S_IDLE;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        if (r_clr_addr == CLR_LAST) begin
                            r_state <= S_REQ;
                        end else begin
                            r_clr_addr <= r_clr_addr + 9'd1;
                        end
                    end
                    S_REQ: begin
                        if (rnd.render_ack) begin
                            r_state <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (rnd.render_done) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // NOTE: strobes are pure decodes of registered state, so no input can
    // reach an output within the same cycle.
    assign clr_we           = (r_state == S_CLEAR);
    assign clr_addr         = r_clr_addr;
    assign disp_bank        = r_disp_bank;
    assign overrun          = r_overrun;
    assign overrun_cnt      = r_overrun_cnt;
    assign rnd.render_req   = (r_state == S_REQ);
    assign rnd.render_line  = r_render_line;
    assign rnd.render_bank  = ~r_disp_bank;
    assign rnd.render_abort = r_render_abort;

endmodule

// File: tb/tb_raizing_line_sched.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a timestamp-based line model.
module tb_raizing_line_sched;

    localparam int CLEAR_LEN = 320;
    localparam int LAST_LINE = 239;

    logic       clk;
    logic       reset_n;
    logic       lhbl;
    logic [8:0] vrender;
    logic       disp_bank;
    logic       clr_we;
    logic [8:0] clr_addr;
    logic       overrun;
    logic [7:0] overrun_cnt;

    raizing_line_sched_if rif ();

    raizing_line_sched #(
        .CLEAR_LEN (CLEAR_LEN),
        .LAST_LINE (LAST_LINE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lhbl        (lhbl),
        .vrender     (vrender),
        .rnd         (rif),
        .disp_bank   (disp_bank),
        .clr_we      (clr_we),
        .clr_addr    (clr_addr),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // {disp_bank, render_bank, render_line, clr_we, clr_addr, render_req, overrun, render_abort, overrun_cnt}
    function automatic logic [31:0] outs();
        return {disp_bank, rif.render_bank, rif.render_line, clr_we, clr_addr,
                rif.render_req, overrun, rif.render_abort, overrun_cnt};
    endfunction

    // Model: a line job is described by the cycle its clear began and whether it
    // has been acked; the phase at any cycle follows from elapsed time.
    int         cyc = 0;
    bit         m_lhbl_d = 1'b1;
    bit         m_active = 1'b0;
    int         m_start = 0;
    bit         m_acked = 1'b0;
    bit         m_disp = 1'b0;
    logic [8:0] m_line = '0;
    logic [7:0] m_cnt = '0;
    bit         m_ov = 1'b0;
    bit         m_ab = 1'b0;

    // 0 idle, 1 clearing, 2 requesting, 3 rendering
    function automatic int phase_of(input int c);
        if (!m_active) return 0;
        if (c - m_start < CLEAR_LEN) return 1;
        if (!m_acked) return 2;
        return 3;
    endfunction

    task automatic model_step();
        int p;
        bit ls;
        p = phase_of(cyc);
        if (!reset_n) begin
            m_active = 1'b0; m_disp = 1'b0; m_line = '0; m_cnt = '0;
            m_ov = 1'b0; m_ab = 1'b0; m_lhbl_d = 1'b1;
        end else begin
            ls = m_lhbl_d && !lhbl;
            m_ov = 1'b0;
            m_ab = 1'b0;
            if (ls) begin
                if (p != 0 && !(p == 3 && rif.render_done)) begin
                    m_ov = 1'b1;
                    m_ab = (p >= 2);
                    if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
                end
                m_disp = !m_disp;
                m_line = vrender;
                if (int'(vrender) <= LAST_LINE) begin
                    m_active = 1'b1;
                    m_start  = cyc + 1;
                    m_acked  = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end else if (p == 2 && rif.render_ack) begin
                m_acked = 1'b1;
            end else if (p == 3 && rif.render_done) begin
                m_active = 1'b0;
            end
            m_lhbl_d = lhbl;
        end
        cyc++;
    endtask

    always @(posedge clk) begin
        int p;
        logic [8:0] exp_addr;
        logic [8:0] act_addr;
        logic [31:0] exp_v;
        logic [31:0] act_v;
        model_step();
        #1;
        p = phase_of(cyc);
        exp_addr = (p == 1) ? 9'(cyc - m_start) : 9'd0;
        act_addr = (p == 1) ? clr_addr : 9'd0;
        exp_v = {m_disp, !m_disp, m_line, p == 1, exp_addr, p == 2, m_ov, m_ab, m_cnt};
        act_v = {disp_bank, rif.render_bank, rif.render_line, clr_we, act_addr,
                 rif.render_req, overrun, rif.render_abort, overrun_cnt};
        check("model_cycle", act_v, exp_v);
    end

    task automatic wait_req(input int bound);
        int n = 0;
        while (!rif.render_req && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("req_reached", {31'd0, rif.render_req}, 32'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [31:0] RESET_OUTS = {1'b0, 1'b1, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0};

    initial begin
        int n;
        int len;
        int lowlen;
        reset_n = 1'b0;
        lhbl = 1'b1;
        vrender = '0;
        rif.render_ack = 1'b0;
        rif.render_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), RESET_OUTS);
        reset_n = 1'b1;
        @(negedge clk);

        // First line: bank swap, full clear, request
        lhbl = 1'b0; vrender = 9'd10;
        @(negedge clk);
        lhbl = 1'b1;
        check("ls_disp_bank", {31'd0, disp_bank}, 32'd1);
        check("ls_render_bank", {31'd0, rif.render_bank}, 32'd0);
        check("ls_render_line", {23'd0, rif.render_line}, 32'd10);
        check("ls_clear_start", {22'd0, clr_we, clr_addr}, {22'd0, 1'b1, 9'd0});
        n = 0;
        while (clr_we && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("clear_len", n, 32'd320);
        check("req_after_clear", {31'd0, rif.render_req}, 32'd1);
        n = 0;
        repeat (5) begin
            if (rif.render_req) n++;
            @(negedge clk);
        end
        check("req_held_no_ack", n, 32'd5);
        rif.render_ack = 1'b1;
        @(negedge clk);
        rif.render_ack = 1'b0;
        check("req_drop_after_ack", {31'd0, rif.render_req}, 32'd0);
        repeat (19) @(negedge clk);
        rif.render_done = 1'b1;
        @(negedge clk);
        rif.render_done = 1'b0;
        repeat (3) @(negedge clk);

        // Swap-only line
        lhbl = 1'b0; vrender = 9'd250;
        @(negedge clk);
        lhbl = 1'b1;
        check("swap_disp_bank", {31'd0, disp_bank}, 32'd0);
        check("swap_render_line", {23'd0, rif.render_line}, 32'd250);
        check("swap_no_overrun", {30'd0, overrun, rif.render_abort}, 32'd0);
        n = 0;
        repeat (20) begin
            if (clr_we || rif.render_req) n++;
            @(negedge clk);
        end
        check("swap_stays_idle", n, 32'd0);

        // Overrun while BUSY
        lhbl = 1'b0; vrender = 9'd20;
        @(negedge clk);
        lhbl = 1'b1;
        check("idle_ls_no_overrun", {31'd0, overrun}, 32'd0);
        wait_req(400);
        rif.render_ack = 1'b1;
        @(negedge clk);
        rif.render_ack = 1'b0;
        repeat (10) @(negedge clk);
        lhbl = 1'b0; vrender = 9'd21;
        @(negedge clk);
        lhbl = 1'b1;
        check("busy_overrun", {22'd0, overrun, rif.render_abort, overrun_cnt},
              {22'd0, 1'b1, 1'b1, 8'd1});
        check("busy_restart", {22'd0, clr_we, clr_addr}, {22'd0, 1'b1, 9'd0});
        check("busy_new_line", {23'd0, rif.render_line}, 32'd21);
        @(negedge clk);
        check("pulse_one_cycle", {30'd0, overrun, rif.render_abort}, 32'd0);

        // Overrun while CLEAR, repeated until saturation
        for (int i = 0; i < 300; i++) begin
            lhbl = 1'b0; vrender = 9'd30;
            @(negedge clk);
            lhbl = 1'b1;
            if (i == 0) check("clear_overrun", {30'd0, overrun, rif.render_abort}, 32'd2);
            @(negedge clk);
        end
        check("overrun_saturate", {24'd0, overrun_cnt}, 32'd255);

        // Done coincident with line start in BUSY
        wait_req(400);
        rif.render_ack = 1'b1;
        @(negedge clk);
        rif.render_ack = 1'b0;
        repeat (5) @(negedge clk);
        lhbl = 1'b0; vrender = 9'd40; rif.render_done = 1'b1;
        @(negedge clk);
        lhbl = 1'b1; rif.render_done = 1'b0;
        check("done_at_ls", {20'd0, overrun, rif.render_abort, clr_we, clr_addr},
              {20'd0, 1'b0, 1'b0, 1'b1, 9'd0});
        check("done_at_ls_line", {23'd0, rif.render_line}, 32'd40);

        // Reset mid-clear
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_mid_clear", outs(), RESET_OUTS);
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized lines, renderer latency and handshake noise
        for (int ln = 0; ln < 30; ln++) begin
            lhbl = 1'b0;
            if (ln == 0) vrender = 9'd239;
            else if (ln == 1) vrender = 9'd240;
            else if ($urandom_range(0, 3) == 0) vrender = 9'($urandom_range(240, 511));
            else vrender = 9'($urandom_range(0, 239));
            len = $urandom_range(330, 560);
            lowlen = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                if (k == lowlen) lhbl = 1'b1;
                rif.render_ack = ($urandom_range(0, 2) == 0);
                rif.render_done = ($urandom_range(0, 60) == 0);
                @(negedge clk);
            end
        end
        rif.render_ack = 1'b0;
        rif.render_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/raizing_line_sched.md
# raizing_line_sched

Per-scanline line-buffer scheduler for the Raizing video pipeline, running on the 96 MHz video clock alongside the video timer. At each horizontal-blank start it swaps the two line-buffer banks, clears the bank about to be rendered, and hands the upcoming render line (`vrender`) to the sprite/tile renderer with a req/ack/done handshake. A render that has not finished by the next line start is aborted and counted as an overrun.

## Interface
- `CLEAR_LEN`, default 320: pixels cleared per line; also the clear address range 0..CLEAR_LEN-1, CLEAR_LEN ≤ 512.
- `LAST_LINE`, default 239: highest `vrender` value that is rendered; larger values are swap-only lines.
- `clk`  in  1  video clock, 96 MHz; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `lhbl`  in  1  horizontal blank, active low, from the video timer.
- `vrender`  in  9  line to render next, from the video timer, already flip-corrected.
- `render_ack`  in  1  renderer accepted the request.
- `render_done`  in  1  one-cycle pulse: renderer finished the line.
- `render_req`  out  1  render request; held until acked.
- `render_line`  out  9  line latched at line start; stable from REQ through BUSY.
- `render_bank`  out  1  bank being cleared and rendered; always `~disp_bank`.
- `render_abort`  out  1  one-cycle pulse: the renderer must drop its current line.
- `disp_bank`  out  1  bank scanned out during the current line.
- `clr_we`  out  1  clear-write strobe to bank `render_bank`; write data is zero and external.
- `clr_addr`  out  9  clear address.
- `overrun`  out  1  one-cycle pulse when a line start finds the scheduler not IDLE.
- `overrun_cnt`  out  8  saturating overrun count; cleared only by reset.

## Operation
- Line-start event (`ls`): `lhbl` is registered as `lhbl_d`. `ls = lhbl_d & ~lhbl`, evaluated every `clk`. The event does not depend on `pxl_cen`.
- States:
  - IDLE: waiting for the next line start.
  - CLEAR: clearing the render bank.
  - REQ: requesting a render.
  - BUSY: waiting for the renderer to finish.
- On `ls`, from any state:
  - toggle `disp_bank`;
  - latch `render_line <= vrender`;
  - if `vrender ≤ LAST_LINE`, go to CLEAR with `clr_addr = 0`; otherwise go to IDLE, with no clear and no request.
- CLEAR:
  - `clr_we = 1`; `clr_addr` increments by 1 each cycle.
  - After the cycle with `clr_addr = CLEAR_LEN-1`, go to REQ.
- REQ:
  - `render_req = 1`.
  - When `render_ack` is sampled 1, go to BUSY.
  - `render_done` is ignored in REQ, including when it arrives in the same cycle as `render_ack`.
- BUSY: on `render_done`, go to IDLE.
- `render_done` is ignored in IDLE and CLEAR.
- `ls` while not IDLE:
  - `overrun` pulses and `overrun_cnt` increments, saturating at 255.
  - `render_abort` pulses if the state was REQ or BUSY.
  - The new sequence starts in the same edge, exactly as above.
  - Exception: in BUSY, if `render_done` arrives in the same cycle as `ls`, it counts as completion. No overrun and no abort are raised, and the new sequence starts normally.
- Reset values: state IDLE; `lhbl_d = 1`; all outputs 0, including `disp_bank`, `render_bank` = 1, `render_line`, `clr_addr` and `overrun_cnt`.
- Reset mid-operation returns everything to the reset values on the next edge. No abort pulse is issued on reset.

## Timing
- Outputs are registered. `render_req`, `clr_we`, `render_abort` and `overrun` are decoded from registered state or are registers themselves. No input reaches an output combinationally.
- `ls` is detected in cycle N, i.e. the first cycle with `lhbl = 0` after `lhbl = 1`.
  - Cycle N+1: new `disp_bank`, new `render_line`; `clr_we = 1`, `clr_addr = 0`; `overrun` and `render_abort` high if applicable.
  - Cycles N+1 .. N+CLEAR_LEN: clear writes.
  - Cycle N+CLEAR_LEN+1: `render_req = 1`.
- `render_ack` high in cycle M (while in REQ): `render_req` is 0 from M+1.
- `render_done` in cycle D (while in BUSY): state is IDLE at D+1.
- Minimum line period for the full clear plus handshake: CLEAR_LEN + 3 cycles. A 96 MHz line is far longer than this, so overruns come from renderer time only.

## Test plan
- Reset, then `lhbl` 1→0 with `vrender = 10` → 1 cycle later `disp_bank = 1`, `render_bank = 0`, `render_line = 10`; `clr_we` high for exactly 320 cycles with addresses 0..319; then `render_req = 1`.
- `render_ack` held low for 5 cycles, then high for 1 cycle → `render_req` stays high 5 cycles and drops the cycle after ack; `render_done` 20 cycles later → IDLE; next `ls` gives no overrun.
- `vrender = 250` at `ls` → bank toggles, `render_line = 250`; no `clr_we`, no `render_req`; state stays IDLE.
- `ls` while BUSY, no done → `overrun` and `render_abort` each 1-cycle pulses; `overrun_cnt = 1`; new clear starts at addr 0 on the same cycle.
- `ls` while CLEAR → `overrun` pulses; `render_abort` stays 0. Repeat 300 times → `overrun_cnt` saturates at 255.
- `render_done` coincident with `ls` in BUSY → no overrun, no abort; new sequence starts. Separately, `reset_n = 0` mid-CLEAR → next cycle all outputs 0 and IDLE.
